// File: rtl/snina_pkg.sv
// Shared types and index helpers for the SNINA AND pipeline (shares x copies layout).
package snina_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    ALARM = 1'b1
  } alarm_state_e;

  localparam int unsigned DEF_NSHARES   = 3;
  localparam int unsigned DEF_NCOPIES   = 3;
  localparam int unsigned DEF_ERR_CNT_W = 8;
  localparam int unsigned DEF_SHARE_W   = DEF_NSHARES * DEF_NCOPIES;
  localparam int unsigned DEF_NR        = (DEF_NSHARES * (DEF_NSHARES - 1)) / 2;
  localparam int unsigned DEF_PROD_W    = DEF_NSHARES * DEF_NSHARES * DEF_NCOPIES;

  function automatic int unsigned nr(input int unsigned nshares);
    return (nshares * (nshares - 1)) / 2;
  endfunction

  // Only defined for i < j; callers order the pair first.
  function automatic int unsigned pair_idx(input int unsigned i, input int unsigned j,
                                           input int unsigned nshares);
    return i * nshares - (i * (i + 1)) / 2 + (j - i - 1);
  endfunction

  function automatic int unsigned share_w(input int unsigned nshares, input int unsigned ncopies);
    return nshares * ncopies;
  endfunction

  function automatic int unsigned prod_w(input int unsigned nshares, input int unsigned ncopies);
    return nshares * nshares * ncopies;
  endfunction

  // Flattened position of cross product u[i][j], copy k.
  function automatic int unsigned prod_bit(input int unsigned i, input int unsigned j,
                                           input int unsigned k, input int unsigned nshares,
                                           input int unsigned ncopies);
    return (i * nshares + j) * ncopies + k;
  endfunction

endpackage

// File: rtl/snina_and_pipe_if.sv
// Operand/result bus of the SNINA AND pipeline; master drives operands, slave returns results.
interface snina_and_pipe_if
  import snina_pkg::*;
#(
  parameter int unsigned NSHARES = DEF_NSHARES,
  parameter int unsigned NCOPIES = DEF_NCOPIES
);

  logic                               in_valid;
  logic [NSHARES*NCOPIES-1:0]         a;
  logic [NSHARES*NCOPIES-1:0]         b;
  logic [(NSHARES*(NSHARES-1))/2-1:0] r;
  logic                               out_valid;
  logic [NSHARES*NCOPIES-1:0]         c;
  logic [NSHARES-1:0]                 err_share;

  modport master (
    output in_valid, a, b, r,
    input  out_valid, c, err_share
  );

  modport slave (
    input  in_valid, a, b, r,
    output out_valid, c, err_share
  );

endinterface

// File: rtl/snina_cross_mul.sv
// Stage 1: registers every share cross product per copy, off-diagonal terms refreshed by r.
module snina_cross_mul
  import snina_pkg::*;
#(
  parameter int unsigned NSHARES = DEF_NSHARES,
  parameter int unsigned NCOPIES = DEF_NCOPIES
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     in_valid,
  input  logic [NSHARES*NCOPIES-1:0]               a,
  input  logic [NSHARES*NCOPIES-1:0]               b,
  input  logic [(NSHARES*(NSHARES-1))/2-1:0]       r,
  output logic                                     v1,
  output logic [NSHARES*NSHARES*NCOPIES-1:0]       u
);

  localparam int unsigned PW = NSHARES * NSHARES * NCOPIES;

  logic [PW-1:0] u_d;

  for (genvar gi = 0; gi < NSHARES; gi++) begin : g_row
    for (genvar gj = 0; gj < NSHARES; gj++) begin : g_col
      for (genvar gk = 0; gk < NCOPIES; gk++) begin : g_copy
        // Both u[i][j] and u[j][i] take the same r bit so it cancels in the unmasked XOR.
        if (gi == gj) begin : g_diag
          assign u_d[prod_bit(gi, gj, gk, NSHARES, NCOPIES)] =
            a[gi*NCOPIES+gk] & b[gj*NCOPIES+gk];
        end else if (gi < gj) begin : g_upper
          assign u_d[prod_bit(gi, gj, gk, NSHARES, NCOPIES)] =
            (a[gi*NCOPIES+gk] & b[gj*NCOPIES+gk]) ^ r[pair_idx(gi, gj, NSHARES)];
        end else begin : g_lower
          assign u_d[prod_bit(gi, gj, gk, NSHARES, NCOPIES)] =
            (a[gi*NCOPIES+gk] & b[gj*NCOPIES+gk]) ^ r[pair_idx(gj, gi, NSHARES)];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v1 <= 1'b0;
      u  <= '0;
    end else begin
      v1 <= in_valid;
      if (in_valid) begin
        u <= u_d;
      end
    end
  end

endmodule

// File: rtl/snina_and_pipe.sv
// Two-stage masked, copy-checked AND with sticky alarm and output zeroization.
// Optional saturating fault counter enabled by defining SNINA_ERR_CNT_EN.
module snina_and_pipe
  import snina_pkg::*;
#(
  parameter int unsigned NSHARES   = DEF_NSHARES,
  parameter int unsigned NCOPIES   = DEF_NCOPIES,
  parameter int unsigned ERR_CNT_W = DEF_ERR_CNT_W
) (
  input  logic                 clk,
  input  logic                 reset,
  snina_and_pipe_if.slave      bus,
  input  logic                 alarm_clr,
  output logic                 alarm,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int unsigned SW = NSHARES * NCOPIES;
  localparam int unsigned PW = NSHARES * NSHARES * NCOPIES;

  logic          v1;
  logic [PW-1:0] u;

  logic [SW-1:0]      c_d;
  logic [NSHARES-1:0] err_d;

  logic               out_valid_q;
  logic [SW-1:0]      c_q;
  logic [NSHARES-1:0] err_q;
  logic               fault;

  alarm_state_e state_q, state_d;

  snina_cross_mul #(
    .NSHARES (NSHARES),
    .NCOPIES (NCOPIES)
  ) u_cross (
    .clk      (clk),
    .reset    (reset),
    .in_valid (bus.in_valid),
    .a        (bus.a),
    .b        (bus.b),
    .r        (bus.r),
    .v1       (v1),
    .u        (u)
  );

  for (genvar gi = 0; gi < NSHARES; gi++) begin : g_share
    logic [NSHARES-1:0] row_mism;

    for (genvar gk = 0; gk < NCOPIES; gk++) begin : g_compress
      logic [NSHARES-1:0] col;
      for (genvar gj = 0; gj < NSHARES; gj++) begin : g_term
        assign col[gj] = u[prod_bit(gi, gj, gk, NSHARES, NCOPIES)];
      end
      assign c_d[gi*NCOPIES+gk] = ^col;
    end

    // A product row is consistent only when its copies are all 0 or all 1.
    for (genvar gj = 0; gj < NSHARES; gj++) begin : g_check
      logic [NCOPIES-1:0] cps;
      for (genvar gk = 0; gk < NCOPIES; gk++) begin : g_bit
        assign cps[gk] = u[prod_bit(gi, gj, gk, NSHARES, NCOPIES)];
      end
      assign row_mism[gj] = ~((&cps) | ~(|cps));
    end

    assign err_d[gi] = |row_mism;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      c_q         <= '0;
      err_q       <= '0;
    end else begin
      out_valid_q <= v1;
      if (v1) begin
        c_q   <= c_d;
        err_q <= err_d;
      end else begin
        err_q <= '0;
      end
    end
  end

  assign fault = out_valid_q & (|err_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (fault) state_d = ALARM;
      ALARM:   if (alarm_clr && !fault) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  assign alarm         = (state_q == ALARM) | fault;
  assign bus.out_valid = out_valid_q;
  assign bus.err_share = err_q;
  assign bus.c         = alarm ? '0 : c_q;

`ifdef SNINA_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_cnt_q <= '0;
    end else if (fault && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_snina_and_pipe.sv
// Directed + randomized bench for snina_and_pipe against a share-algebra reference model.
module tb_snina_and_pipe;

  localparam int unsigned NS  = 3;
  localparam int unsigned NC  = 3;
  localparam int unsigned CW  = 3;
  localparam int unsigned CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          alarm_clr;
  logic          alarm;
  logic [CW-1:0] err_cnt;

  snina_and_pipe_if #(.NSHARES(NS), .NCOPIES(NC)) bus ();

  snina_and_pipe #(
    .NSHARES   (NS),
    .NCOPIES   (NC),
    .ERR_CNT_W (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .alarm_clr (alarm_clr),
    .alarm     (alarm),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  int unsigned pidx [NS][NS];

  // Reference model state: operand in stage 1, result registers, alarm and counter.
  logic        m1v = 1'b0;
  logic [8:0]  m1a = '0, m1b = '0;
  logic [2:0]  m1r = '0;
  logic        ov_m = 1'b0;
  logic [8:0]  c_m = '0;
  logic [8:0]  m2a = '0, m2b = '0;
  logic [2:0]  err_m = '0;
  logic        alarm_m = 1'b0;
  int unsigned cnt_m = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] rep(input logic [2:0] s);
    logic [8:0] x;
    x = '0;
    for (int i = 0; i < NS; i++)
      for (int k = 0; k < NC; k++)
        x[i*NC+k] = s[i];
    return x;
  endfunction

  // Per copy, XOR of all shares: the unshared value.
  function automatic logic [2:0] unmask(input logic [8:0] x);
    logic [2:0] v;
    v = '0;
    for (int k = 0; k < NC; k++)
      for (int i = 0; i < NS; i++)
        v[k] = v[k] ^ x[i*NC+k];
    return v;
  endfunction

  // c_i = a_i & (sum of b shares) ^ (sum of r bits over pairs containing i)
  function automatic logic [8:0] exp_shares(input logic [8:0] ea, input logic [8:0] eb,
                                            input logic [2:0] er);
    logic [8:0] x;
    logic [2:0] bu;
    bu = unmask(eb);
    x  = '0;
    for (int i = 0; i < NS; i++)
      for (int k = 0; k < NC; k++) begin
        x[i*NC+k] = ea[i*NC+k] & bu[k];
        for (int j = 0; j < NS; j++)
          if (j != i) x[i*NC+k] = x[i*NC+k] ^ er[(i < j) ? pidx[i][j] : pidx[j][i]];
      end
    return x;
  endfunction

  function automatic logic [2:0] exp_err(input logic [8:0] ea, input logic [8:0] eb);
    logic [2:0] e;
    logic       p0;
    e = '0;
    for (int i = 0; i < NS; i++)
      for (int j = 0; j < NS; j++) begin
        p0 = ea[i*NC] & eb[j*NC];
        for (int k = 1; k < NC; k++)
          if ((ea[i*NC+k] & eb[j*NC+k]) != p0) e[i] = 1'b1;
      end
    return e;
  endfunction

  task automatic model_edge(input logic v, input logic [8:0] ta, input logic [8:0] tbv,
                            input logic [2:0] tr, input logic clr, input logic rst);
    logic fault_prev;
    if (rst) begin
      m1v = 1'b0; ov_m = 1'b0; c_m = '0; err_m = '0; alarm_m = 1'b0; cnt_m = 0;
    end else begin
      fault_prev = ov_m & (|err_m);
      if (fault_prev) alarm_m = 1'b1;
      else if (alarm_m && clr) alarm_m = 1'b0;
      if (fault_prev && cnt_m != CNT_MAX) cnt_m++;
      ov_m = m1v;
      if (m1v) begin
        c_m = exp_shares(m1a, m1b, m1r);
        err_m = exp_err(m1a, m1b);
        m2a = m1a; m2b = m1b;
      end else begin
        err_m = '0;
      end
      m1v = v;
      if (v) begin m1a = ta; m1b = tbv; m1r = tr; end
    end
  endtask

  task automatic check_out();
    logic fault_now, al;
    logic [63:0] exp_cnt;
    fault_now = ov_m & (|err_m);
    al = alarm_m | fault_now;
`ifdef SNINA_ERR_CNT_EN
    exp_cnt = 64'(cnt_m);
`else
    exp_cnt = '0;
`endif
    chk("out_valid", 64'(bus.out_valid), 64'(ov_m));
    chk("err_share", 64'(bus.err_share), 64'(err_m));
    chk("alarm",     64'(alarm), 64'(al));
    chk("c",         64'(bus.c), al ? 64'd0 : 64'(c_m));
    chk("err_cnt",   64'(err_cnt), exp_cnt);
    if (ov_m && !al)
      chk("unmasked_c", 64'(unmask(bus.c)), 64'(unmask(m2a) & unmask(m2b)));
  endtask

  task automatic step(input logic v, input logic [8:0] ta, input logic [8:0] tbv,
                      input logic [2:0] tr, input logic clr, input logic rst);
    @(negedge clk);
    bus.in_valid = v; bus.a = ta; bus.b = tbv; bus.r = tr;
    alarm_clr = clr; reset = rst;
    @(posedge clk);
    model_edge(v, ta, tbv, tr, clr, rst);
    #1;
    check_out();
  endtask

  task automatic rand_op(input logic v, input logic clr);
    step(v, rep(3'($urandom)), rep(3'($urandom)), 3'($urandom), clr, 1'b0);
  endtask

  task automatic fault_op(input logic clr);
    logic [8:0] fa;
    fa = rep(3'($urandom));
    fa[$urandom_range(8, 0)] ^= 1'b1;
    step(1'b1, fa, 9'h1FF, 3'($urandom), clr, 1'b0);
  endtask

  task automatic idle(input logic clr);
    step(1'b0, '0, '0, '0, clr, 1'b0);
  endtask

  initial begin
    int unsigned n;
    n = 0;
    for (int i = 0; i < NS; i++)
      for (int j = i + 1; j < NS; j++) begin
        pidx[i][j] = n;
        n++;
      end

    reset = 1'b1; alarm_clr = 1'b0;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.r = '0;

    // Reset state
    step(1'b0, '0, '0, '0, 1'b0, 1'b1);
    step(1'b0, '0, '0, '0, 1'b0, 1'b1);

    // Single op: unshared a = 0, b = 0
    step(1'b1, 9'b111_111_000, 9'b000_111_111, 3'b101, 1'b0, 1'b0);
    idle(1'b0);
    chk("single_unmask", 64'(unmask(bus.c)), 64'd0);
    idle(1'b0);

    // Back-to-back
    for (int i = 0; i < 10; i++) rand_op(1'b1, 1'b0);
    idle(1'b0); idle(1'b0);

    // Bubbles 1,0,1
    rand_op(1'b1, 1'b0); rand_op(1'b0, 1'b0); rand_op(1'b1, 1'b0);
    idle(1'b0); idle(1'b0); idle(1'b0);

    // Injected fault in copy 1 of share 2
    step(1'b1, 9'b101_000_111, 9'b101_000_000, 3'b011, 1'b0, 1'b0);
    idle(1'b0);
    chk("fault_err_share", 64'(bus.err_share), 64'b101);
    chk("fault_alarm", 64'(alarm), 64'd1);
    for (int i = 0; i < 3; i++) rand_op(1'b1, 1'b0);
    idle(1'b0); idle(1'b0);

    // Clear racing a new fault, then a clean clear
    fault_op(1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b0);
    idle(1'b1);
    chk("clear_alarm", 64'(alarm), 64'd0);
    for (int i = 0; i < 4; i++) rand_op(1'b1, 1'b0);
    idle(1'b0); idle(1'b0);

    // Fault burst (counter saturation when enabled)
    for (int i = 0; i < 9; i++) fault_op(1'b0);
    idle(1'b0); idle(1'b0); idle(1'b1); idle(1'b0);

    // Reset mid-pipe
    rand_op(1'b1, 1'b0);
    step(1'b0, '0, '0, '0, 1'b0, 1'b1);
    idle(1'b0); idle(1'b0);

    // Random mix
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(7, 0) == 0) fault_op(1'($urandom));
      else rand_op(1'($urandom), 1'($urandom));
    end
    idle(1'b0); idle(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/snina_and_pipe.md
Name: snina_and_pipe

Overview:
- Parametrised successor of the fixed 3-share / 3-copy SNINA AND gadget. Supports NSHARES Boolean shares, each encoded as NCOPIES identical copies (repetition code).
- Stage 1 registers all cross products plus refresh randomness. Stage 2 compresses them and checks copy consistency for each share.
- Adds a valid-qualified pipeline, a sticky alarm FSM with output zeroization, and an optional fault counter.
- Sits between masked S-box AND layers and the fault-response controller.

Parameters:
- NSHARES, 3, number of shares (masking order d = NSHARES-1), >= 2
- NCOPIES, 3, copies per share bit (detection order k = NCOPIES-1), >= 2
- ERR_CNT_W, 8, width of the fault counter; used only when SNINA_ERR_CNT_EN is defined

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  a, b, r are valid this cycle
- a  in  NSHARES*NCOPIES  share i, copy k at bit i*NCOPIES+k
- b  in  NSHARES*NCOPIES  same layout as a
- r  in  NR  fresh randomness, NR = NSHARES*(NSHARES-1)/2
- alarm_clr  in  1  request to leave ALARM
- out_valid  out  1  c and err_share are valid
- c  out  NSHARES*NCOPIES  output shares, same layout as a
- err_share  out  NSHARES  1 = copy mismatch detected in a product row of share i
- alarm  out  1  sticky fault alarm
- err_cnt  out  ERR_CNT_W  saturating count of faulty results (only with SNINA_ERR_CNT_EN)

Behaviour:
- The interface is fixed as: one clock; reset is synchronous and active-high (ports clk, reset).
- Reset values: out_valid=0, c=0, err_share=0, alarm=0, err_cnt=0, FSM=RUN, all stage valids=0.
- Pair index: for i<j, p(i,j) = i*NSHARES - i*(i+1)/2 + (j-i-1). For NSHARES=3 this gives (0,1)=0, (0,2)=1, (1,2)=2.
- Stage 1 (registered when in_valid=1, per copy k):
  - u[i][i][k] = a[i][k] & b[i][k]
  - u[i][j][k] = (a[i][k] & b[j][k]) ^ r[p(min,max)] for i != j
  - The same r bit is applied to every copy.
  - v1 <= in_valid. When in_valid=0 the u registers hold and v1=0.
- Stage 2 (registered):
  - c[i][k] = XOR over j of u[i][j][k]
  - err_share[i] = OR over j of (copies of u[i][j] not all equal)
  - out_valid <= v1. When v1=0, err_share is forced to 0 and c holds.
- Latency: exactly 2 cycles from an accepted input to out_valid. Throughput is one result per cycle; there is no backpressure.
- fault = out_valid & |err_share (combinational from stage-2 regs).
- FSM:
  - RUN -> ALARM on fault.
  - ALARM -> RUN on alarm_clr only when fault=0 that cycle. Fault wins over a simultaneous clear.
- alarm = (state==ALARM) | fault. The alarm is visible in the same cycle as the faulty result.
- While alarm=1, c is presented as all zeros; out_valid and err_share are still reported unmodified.
- Bubbles (in_valid=0) propagate as out_valid=0 and never raise a fault.
- Reset mid-operation flushes both stages; results in flight are discarded and never emitted.

Optional Feature:
- SNINA_ERR_CNT_EN defined: err_cnt increments by 1 on each cycle with fault=1 and saturates at all-ones. It is cleared only by reset, not by alarm_clr.
- Not defined: err_cnt is tied to 0 and no counter register exists.

Decomposition:
- Package snina_pkg holds:
  - function nr(NSHARES)
  - function pair_idx(i, j, NSHARES)
  - state enum {RUN, ALARM}
  - localparams for flattened widths
- Sub-module snina_cross_mul: the stage-1 products, randomness and register, with v1.
- Compression, detection and the FSM live in the top module.

Test Plan (NSHARES=3, NCOPIES=3):
- Single op: a shares 0,1,1 (all copies, unshared a=0) and b shares 1,1,0 (unshared b=0), r=3'b101 -> out_valid on cycle +2, XOR of c shares = 0 on every copy, err_share=0, alarm=0.
- Back-to-back: 10 consecutive ops with random a, b, r -> 10 consecutive out_valid pulses, each unmasked c equal to a&b, in input order.
- Injected fault: copy 1 of a share 2 differs from copies 0 and 2 -> err_share[0]=1 and err_share[2]=1 at cycle +2, alarm=1, c=0. alarm stays 1 on later clean ops; err_cnt=1 with SNINA_ERR_CNT_EN.
- Clear race: alarm_clr asserted in the same cycle as a new fault -> state stays ALARM. alarm_clr on a clean cycle -> alarm=0 on the next cycle, with correct outputs.
- Bubbles: pattern in_valid=1,0,1 -> out_valid=1,0,1 after 2 cycles. No fault from stale data.
- Reset mid-pipe: reset asserted 1 cycle after in_valid -> out_valid stays 0, alarm=0, err_cnt=0.
